// File: rtl/enc_pkg.sv
// Shared types and sizing for the sequential priority encoder.
// The code width is derived from N and is never overridden on its own.
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int N_DEFAULT = 8;

  function automatic int code_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_first_set.sv
// Combinational find-first-set: index of the lowest set bit, and whether it is the only one.
// An all-zero vector yields code 0 with onehot_last low.
module lsb_first_set
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = code_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code,
  output logic         onehot_last
);

  always_comb begin
    // NOTE: assign a default before the loop so every path drives code; otherwise a latch is inferred.
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) code = i[W-1:0];
    end
  end

  assign onehot_last = ($countones(vec) == 1);

endmodule

// File: rtl/seq_priority_encoder.sv
// Captures a request vector and emits the index of each set bit, lowest first,
// one per valid/ready handshake on the output stream.
module seq_priority_encoder
  import enc_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = code_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         zero_pulse,
  output logic         busy
);

  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [N-1:0]   pending;
  logic [W-1:0]   ffs_code;
  logic           ffs_last;

  lsb_first_set #(
    .N(N),
    .W(W)
  ) u_ffs (
    .vec        (pending),
    .code       (ffs_code),
    .onehot_last(ffs_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      zero_pulse <= 1'b0;
    end else begin
      zero_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec != '0) begin
              pending <= in_vec;
              state   <= EMIT;
            end else begin
              zero_pulse <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            // x & (x-1) drops exactly the lowest set bit, i.e. the code just accepted.
            pending <= pending & (pending - LSB_ONE);
            if (ffs_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream outputs decode only registered state; no path from in_vec or out_ready.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign out_code  = ffs_code;
  assign out_last  = ffs_last;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder: each task drives one scenario and checks
// the packed output tuple {in_ready, out_valid, out_code, out_last, zero_pulse, busy}.
module tb_seq_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_last;
  logic         zero_pulse;
  logic         busy;

  int passed = 0;
  int total  = 0;

  seq_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .zero_pulse(zero_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observed tuple, bit layout: [7]=in_ready [6]=out_valid [5:3]=out_code [2]=out_last [1]=zero_pulse [0]=busy
  logic [7:0] obs;
  assign obs = {in_ready, out_valid, out_code, out_last, zero_pulse, busy};

  localparam logic [7:0] IDLE_EXP = 8'b1_0_000_0_0_0;
  localparam logic [7:0] ZERO_EXP = 8'b1_0_000_0_1_0;

  function automatic logic [7:0] emit_exp(input int code, input bit last);
    logic [2:0] c;
    c = code[2:0];
    return {1'b0, 1'b1, c, last, 1'b0, 1'b1};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    step();
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL reset: got %b expected %b", obs, IDLE_EXP);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_vec = 8'b0000_0100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (obs !== emit_exp(2, 1'b1)) $display("FAIL single_code: got %b expected %b", obs, emit_exp(2, 1'b1));
    else passed++;
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL single_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_multi();
    int codes[4] = '{1, 2, 4, 7};
    in_vec = 8'b1001_0110; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== emit_exp(codes[k], k == 3))
        $display("FAIL multi_code%0d: got %b expected %b", k, obs, emit_exp(codes[k], k == 3));
      else passed++;
      step();
    end
    total++;
    if (obs !== IDLE_EXP) $display("FAIL multi_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_stall();
    in_vec = 8'b0000_0011; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs !== emit_exp(0, 1'b0)) $display("FAIL stall_hold%0d: got %b expected %b", k, obs, emit_exp(0, 1'b0));
      else passed++;
      step();
    end
    out_ready = 1'b1;
    total++;
    if (obs !== emit_exp(0, 1'b0)) $display("FAIL stall_code0: got %b expected %b", obs, emit_exp(0, 1'b0));
    else passed++;
    step();
    total++;
    if (obs !== emit_exp(1, 1'b1)) $display("FAIL stall_code1: got %b expected %b", obs, emit_exp(1, 1'b1));
    else passed++;
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL stall_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_zero();
    in_vec = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (obs !== ZERO_EXP) $display("FAIL zero_pulse: got %b expected %b", obs, ZERO_EXP);
    else passed++;
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL zero_after: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_all_ones();
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (obs !== emit_exp(k, k == 7)) $display("FAIL ones_code%0d: got %b expected %b", k, obs, emit_exp(k, k == 7));
      else passed++;
      step();
    end
    total++;
    if (obs !== IDLE_EXP) $display("FAIL ones_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_reset_mid();
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== emit_exp(k, 1'b0)) $display("FAIL midrst_code%0d: got %b expected %b", k, obs, emit_exp(k, 1'b0));
      else passed++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (obs !== IDLE_EXP) $display("FAIL midrst_reset: got %b expected %b", obs, IDLE_EXP);
    else passed++;
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL midrst_quiet: got %b expected %b", obs, IDLE_EXP);
    else passed++;
    in_vec = 8'h80; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (obs !== emit_exp(7, 1'b1)) $display("FAIL midrst_new: got %b expected %b", obs, emit_exp(7, 1'b1));
    else passed++;
    step();
    total++;
    if (obs !== IDLE_EXP) $display("FAIL midrst_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  task automatic test_back_to_back();
    in_vec = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_vec = 8'hF0;  // held with in_valid while busy; must be ignored until IDLE
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== emit_exp(k, k == 3)) $display("FAIL b2b_first%0d: got %b expected %b", k, obs, emit_exp(k, k == 3));
      else passed++;
      step();
    end
    total++;
    if (obs !== IDLE_EXP) $display("FAIL b2b_gap: got %b expected %b", obs, IDLE_EXP);
    else passed++;
    step();
    in_valid = 1'b0;
    for (int k = 4; k < 8; k++) begin
      total++;
      if (obs !== emit_exp(k, k == 7)) $display("FAIL b2b_second%0d: got %b expected %b", k, obs, emit_exp(k, k == 7));
      else passed++;
      step();
    end
    total++;
    if (obs !== IDLE_EXP) $display("FAIL b2b_idle: got %b expected %b", obs, IDLE_EXP);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_all_ones();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
